// File: rtl/uart_fifo_core.sv
// UART core with an oversampled TX/RX pair, each buffered by a small first-word-fall-through FIFO.
// RX FIFO entries carry {frame_err, parity_err, data}, so the error flags track the head entry.

module uart_fifo_core_fifo #(
   parameter int W  = 8,
   parameter int AW = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic         full,
   output logic         empty
);
   localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

   logic [W-1:0]  mem [2**AW];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          push_ok, pop_ok;

   assign full    = (count == DEPTH);
   assign empty   = (count == '0);
   assign pop_ok  = pop && !empty;
   // A push into a full FIFO only lands when the head leaves in the same cycle.
   assign push_ok = push && (!full || pop_ok);
   assign head    = empty ? '0 : mem[rd_ptr];

   // NOTE: storage has no reset; the count gates every read, so stale contents are never visible.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         if (push_ok && !pop_ok)      count <= count + 1'b1;
         else if (pop_ok && !push_ok) count <= count - 1'b1;
      end
   end
endmodule

module uart_fifo_core #(
   parameter int DATA_WIDTH = 8,
   parameter int STOP_WIDTH = 1,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int CLK_DIV    = 163,
   parameter int FIFO_AW    = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_tx_wr,
   input  logic [DATA_WIDTH-1:0] i_data_byte,
   output logic                  o_tx_full,
   output logic                  o_tx_data,
   output logic                  o_tx_busy,
   input  logic                  i_rx_data,
   input  logic                  i_rx_rd,
   output logic [DATA_WIDTH-1:0] o_data_byte,
   output logic                  o_rx_empty,
   output logic                  o_rx_parity_err,
   output logic                  o_rx_frame_err,
   output logic                  o_rx_overrun
);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   localparam int   CW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int   BW  = $clog2(DATA_WIDTH + 1);
   localparam logic ODD = (PARITY_ODD != 0);

   logic [CW-1:0] div_cnt;
   logic          tick;

   assign tick = (div_cnt == CW'(CLK_DIV - 1));

   // NOTE: sequential state uses <= so every flop samples the values from before the edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) div_cnt <= '0;
      else       div_cnt <= tick ? '0 : div_cnt + 1'b1;
   end

   logic [DATA_WIDTH-1:0] tx_head, tx_shift;
   logic                  tx_empty, tx_pop, tx_par;
   state_t                tx_state;
   logic [3:0]            tx_tcnt;
   logic [BW-1:0]         tx_bcnt;

   // The last STOP tick may pop directly so back-to-back frames have no gap.
   assign tx_pop = tick && !tx_empty &&
                   ((tx_state == IDLE) ||
                    (tx_state == STOP && tx_tcnt == 4'd15 && tx_bcnt == BW'(STOP_WIDTH - 1)));

   uart_fifo_core_fifo #(.W(DATA_WIDTH), .AW(FIFO_AW)) u_tx_fifo (
      .clk(clk), .reset(reset), .push(i_tx_wr), .push_data(i_data_byte),
      .pop(tx_pop), .head(tx_head), .full(o_tx_full), .empty(tx_empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_state  <= IDLE;
         tx_tcnt   <= '0;
         tx_bcnt   <= '0;
         tx_shift  <= '0;
         tx_par    <= 1'b0;
         o_tx_data <= 1'b1;
         o_tx_busy <= 1'b0;
      end else if (tx_pop) begin
         tx_state  <= START;
         tx_tcnt   <= '0;
         tx_shift  <= tx_head;
         tx_par    <= ^tx_head ^ ODD;
         o_tx_data <= 1'b0;
         o_tx_busy <= 1'b1;
      end else if (tick && tx_state != IDLE) begin
         tx_tcnt <= tx_tcnt + 4'd1;
         if (tx_tcnt == 4'd15) begin
            case (tx_state)
               START: begin
                  tx_state  <= DATA;
                  tx_bcnt   <= '0;
                  o_tx_data <= tx_shift[0];
               end
               DATA: begin
                  if (tx_bcnt == BW'(DATA_WIDTH - 1)) begin
                     tx_bcnt <= '0;
                     if (PARITY_EN != 0) begin
                        tx_state  <= PARITY;
                        o_tx_data <= tx_par;
                     end else begin
                        tx_state  <= STOP;
                        o_tx_data <= 1'b1;
                     end
                  end else begin
                     tx_bcnt   <= tx_bcnt + 1'b1;
                     tx_shift  <= tx_shift >> 1;
                     o_tx_data <= tx_shift[1];
                  end
               end
               PARITY: begin
                  tx_state  <= STOP;
                  o_tx_data <= 1'b1;
               end
               STOP: begin
                  if (tx_bcnt == BW'(STOP_WIDTH - 1)) begin
                     tx_state  <= IDLE;
                     o_tx_busy <= 1'b0;
                  end else begin
                     tx_bcnt <= tx_bcnt + 1'b1;
                  end
               end
               default: tx_state <= IDLE;
            endcase
         end
      end
   end

   logic [1:0]            rx_sync;
   logic                  rx_s, rx_q, rx_perr, rx_push;
   state_t                rx_state;
   logic [3:0]            rx_tcnt;
   logic [BW-1:0]         rx_bcnt;
   logic [DATA_WIDTH-1:0] rx_shift;
   logic [DATA_WIDTH+1:0] rx_push_data, rx_head;
   logic                  rx_full, rx_empty, rx_pop_ok;

   assign rx_s = rx_sync[1];

   // rx_q holds the previous tick's sample, so start detection needs a real falling edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_sync      <= 2'b11;
         rx_q         <= 1'b1;
         rx_state     <= IDLE;
         rx_tcnt      <= '0;
         rx_bcnt      <= '0;
         rx_shift     <= '0;
         rx_perr      <= 1'b0;
         rx_push      <= 1'b0;
         rx_push_data <= '0;
      end else begin
         rx_sync <= {rx_sync[0], i_rx_data};
         rx_push <= 1'b0;
         if (tick) begin
            rx_q <= rx_s;
            case (rx_state)
               IDLE: begin
                  if (rx_q && !rx_s) begin
                     rx_state <= START;
                     rx_tcnt  <= '0;
                     rx_perr  <= 1'b0;
                  end
               end
               START: begin
                  if (rx_tcnt == 4'd6) begin
                     rx_tcnt  <= '0;
                     rx_bcnt  <= '0;
                     rx_state <= rx_s ? IDLE : DATA;
                  end else begin
                     rx_tcnt <= rx_tcnt + 4'd1;
                  end
               end
               default: begin
                  rx_tcnt <= rx_tcnt + 4'd1;
                  if (rx_tcnt == 4'd15) begin
                     case (rx_state)
                        DATA: begin
                           rx_shift <= {rx_s, rx_shift[DATA_WIDTH-1:1]};
                           if (rx_bcnt == BW'(DATA_WIDTH - 1))
                              rx_state <= (PARITY_EN != 0) ? PARITY : STOP;
                           else
                              rx_bcnt <= rx_bcnt + 1'b1;
                        end
                        PARITY: begin
                           rx_perr  <= rx_s ^ (^rx_shift) ^ ODD;
                           rx_state <= STOP;
                        end
                        STOP: begin
                           rx_push      <= 1'b1;
                           rx_push_data <= {~rx_s, rx_perr, rx_shift};
                           rx_state     <= IDLE;
                        end
                        default: rx_state <= IDLE;
                     endcase
                  end
               end
            endcase
         end
      end
   end

   uart_fifo_core_fifo #(.W(DATA_WIDTH + 2), .AW(FIFO_AW)) u_rx_fifo (
      .clk(clk), .reset(reset), .push(rx_push), .push_data(rx_push_data),
      .pop(i_rx_rd), .head(rx_head), .full(rx_full), .empty(rx_empty)
   );

   assign {o_rx_frame_err, o_rx_parity_err, o_data_byte} = rx_head;
   assign o_rx_empty = rx_empty;
   assign rx_pop_ok  = i_rx_rd && !rx_empty;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                               o_rx_overrun <= 1'b0;
      else if (rx_push && rx_full && !rx_pop_ok) o_rx_overrun <= 1'b1;
      else if (rx_pop_ok)                      o_rx_overrun <= 1'b0;
   end
endmodule

// File: tb/tb_uart_fifo_core.sv
// Scoreboard bench for uart_fifo_core: 8 data bits, even parity, one stop bit, 32 clk per bit.
// Stimulus queues expected RX entries and TX line frames; independent monitors pop and compare.

module tb_uart_fifo_core;
   localparam int PERIOD    = 10;
   localparam int BIT_CLK   = 32;
   localparam int FRAME_CLK = 11 * BIT_CLK;

   typedef struct {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
   } rx_exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       i_tx_wr = 1'b0;
   logic [7:0] i_data_byte = '0;
   logic       o_tx_full, o_tx_data, o_tx_busy;
   logic       i_rx_rd = 1'b0;
   logic [7:0] o_data_byte;
   logic       o_rx_empty, o_rx_parity_err, o_rx_frame_err, o_rx_overrun;
   logic       rx_drv = 1'b1;
   logic       loop_en = 1'b0;
   logic       mon_en = 1'b1;
   logic       txmon_en = 1'b1;
   logic       rx_line;

   int         checks = 0;
   int         failures = 0;
   rx_exp_t    rx_exp[$];
   logic [7:0] tx_exp[$];
   time        t_rise = 0, t_fall = 0;

   assign rx_line = loop_en ? o_tx_data : rx_drv;

   always #(PERIOD/2) clk = ~clk;

   uart_fifo_core #(
      .DATA_WIDTH(8), .STOP_WIDTH(1), .PARITY_EN(1), .PARITY_ODD(0), .CLK_DIV(2), .FIFO_AW(2)
   ) dut (
      .clk(clk), .reset(reset), .i_tx_wr(i_tx_wr), .i_data_byte(i_data_byte),
      .o_tx_full(o_tx_full), .o_tx_data(o_tx_data), .o_tx_busy(o_tx_busy),
      .i_rx_data(rx_line), .i_rx_rd(i_rx_rd), .o_data_byte(o_data_byte),
      .o_rx_empty(o_rx_empty), .o_rx_parity_err(o_rx_parity_err),
      .o_rx_frame_err(o_rx_frame_err), .o_rx_overrun(o_rx_overrun)
   );

   always @(posedge o_tx_busy) t_rise = $time;
   always @(negedge o_tx_busy) t_fall = $time;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // RX monitor: pops the FIFO whenever it presents an entry and checks it against the scoreboard.
   initial begin : rx_mon
      rx_exp_t e;
      forever begin
         @(negedge clk);
         i_rx_rd = 1'b0;
         if (mon_en && !reset && !o_rx_empty) begin
            if (rx_exp.size() == 0) begin
               check("rx_unexpected_entry", o_rx_empty, 1);
            end else begin
               e = rx_exp.pop_front();
               check("rx_data", o_data_byte, e.data);
               check("rx_parity_err", o_rx_parity_err, e.perr);
               check("rx_frame_err", o_rx_frame_err, e.ferr);
            end
            i_rx_rd = 1'b1;
         end
      end
   end

   // TX line monitor: decodes each frame at bit mid-points from the start-bit falling edge.
   initial begin : tx_mon
      logic        prev;
      logic [10:0] bits;
      logic [7:0]  exp_b;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (txmon_en && !reset && prev && !o_tx_data) begin
            repeat (BIT_CLK/2) @(negedge clk);
            bits[0] = o_tx_data;
            for (int k = 1; k < 11; k++) begin
               repeat (BIT_CLK) @(negedge clk);
               bits[k] = o_tx_data;
            end
            if (tx_exp.size() == 0) begin
               check("tx_unexpected_frame", tx_exp.size(), 1);
            end else begin
               exp_b = tx_exp.pop_front();
               check("tx_start_bit", bits[0], 0);
               check("tx_data_bits", bits[8:1], exp_b);
               check("tx_parity_bit", bits[9], ^exp_b);
               check("tx_stop_bit", bits[10], 1);
            end
         end
         prev = o_tx_data;
      end
   end

   task automatic tx_write(input logic [7:0] b);
      int n = 0;
      while (o_tx_full && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) check("tx_full_timeout", n, 0);
      i_tx_wr     = 1'b1;
      i_data_byte = b;
      @(negedge clk);
      i_tx_wr = 1'b0;
      if (txmon_en) tx_exp.push_back(b);
      if (loop_en) rx_exp.push_back('{b, 1'b0, 1'b0});
   endtask

   task automatic send_rx_frame(input logic [7:0] d, input logic par, input logic stop);
      logic [10:0] bits;
      bits = {stop, par, d, 1'b0};
      for (int k = 0; k < 11; k++) begin
         rx_drv = bits[k];
         repeat (BIT_CLK) @(negedge clk);
      end
      rx_drv = 1'b1;
      repeat (BIT_CLK) @(negedge clk);
   endtask

   // Drives a frame and queues what the receiver should report for it.
   task automatic rx_frame_exp(input logic [7:0] d, input logic bad_par, input logic stop_low,
                               input logic expect_push);
      if (expect_push) rx_exp.push_back('{d, bad_par, stop_low});
      send_rx_frame(d, (^d) ^ bad_par, ~stop_low);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((rx_exp.size() != 0 || tx_exp.size() != 0 || !o_rx_empty || o_tx_busy) && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20000) check("idle_timeout", n, 0);
   endtask

   initial begin : watchdog
      #(PERIOD * 90000);
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic [7:0] b;
      int         n;
      int         span;

      repeat (3) @(negedge clk);
      check("rst_tx_data", o_tx_data, 1);
      check("rst_tx_busy", o_tx_busy, 0);
      check("rst_tx_full", o_tx_full, 0);
      check("rst_rx_empty", o_rx_empty, 1);
      check("rst_data_byte", o_data_byte, 0);
      check("rst_parity_err", o_rx_parity_err, 0);
      check("rst_frame_err", o_rx_frame_err, 0);
      check("rst_overrun", o_rx_overrun, 0);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      check("post_rst_tx_data", o_tx_data, 1);
      check("post_rst_rx_empty", o_rx_empty, 1);

      // Loopback of 0xA5 and 0x07; the line monitor checks the even parity bit of 0x07 is 1.
      loop_en = 1'b1;
      tx_write(8'hA5);
      wait_idle();
      tx_write(8'h07);
      wait_idle();

      // Directly driven frames: bad parity on 0x07, low stop bit on 0x3C.
      loop_en = 1'b0;
      rx_frame_exp(8'h07, 1'b1, 1'b0, 1'b1);
      rx_frame_exp(8'h3C, 1'b0, 1'b1, 1'b1);
      wait_idle();

      // Five frames with nobody reading: four kept in order, the fifth dropped.
      mon_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         b = 8'($urandom);
         rx_frame_exp(b, 1'b0, 1'b0, i < 4);
      end
      check("ovr_set", o_rx_overrun, 1);
      check("ovr_rx_not_empty", o_rx_empty, 0);
      mon_en = 1'b1;
      n = 0;
      while (rx_exp.size() >= 4 && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      @(negedge clk);
      check("ovr_cleared_by_read", o_rx_overrun, 0);
      wait_idle();

      // Five consecutive writes while idle: FIFO fills and frames go out with no gaps.
      loop_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         b = 8'($urandom);
         i_tx_wr     = 1'b1;
         i_data_byte = b;
         tx_exp.push_back(b);
         rx_exp.push_back('{b, 1'b0, 1'b0});
         @(negedge clk);
      end
      i_tx_wr = 1'b0;
      check("b2b_tx_full", o_tx_full, 1);
      n = 0;
      while (o_tx_busy && n < 4000) begin
         @(negedge clk);
         n++;
      end
      span = int'((t_fall - t_rise) / PERIOD);
      check("b2b_busy_span", span, 5 * FRAME_CLK);
      wait_idle();

      // Short low glitch must not start a frame; a clean frame afterwards still decodes.
      loop_en = 1'b0;
      rx_drv  = 1'b0;
      repeat (4) @(negedge clk);
      rx_drv = 1'b1;
      repeat (20 * BIT_CLK) @(negedge clk);
      check("glitch_no_push", o_rx_empty, 1);
      rx_frame_exp(8'h5A, 1'b0, 1'b0, 1'b1);
      wait_idle();

      // Randomised traffic through both paths.
      loop_en = 1'b1;
      for (int i = 0; i < 8; i++) tx_write(8'($urandom));
      wait_idle();
      loop_en = 1'b0;
      for (int i = 0; i < 8; i++)
         rx_frame_exp(8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 1'b1);
      wait_idle();

      // Reset in the middle of a transmission with more data still queued.
      txmon_en    = 1'b0;
      i_tx_wr     = 1'b1;
      i_data_byte = 8'h00;
      @(negedge clk);
      @(negedge clk);
      i_tx_wr = 1'b0;
      n = 0;
      while (!o_tx_busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      repeat (100) @(negedge clk);
      check("mid_tx_line_low", o_tx_data, 0);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_tx_data", o_tx_data, 1);
      check("mid_rst_tx_busy", o_tx_busy, 0);
      check("mid_rst_tx_full", o_tx_full, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (3 * FRAME_CLK) @(negedge clk);
      check("post_abort_tx_busy", o_tx_busy, 0);
      check("post_abort_tx_data", o_tx_data, 1);
      check("post_abort_rx_empty", o_rx_empty, 1);
      check("sb_rx_drained", rx_exp.size(), 0);
      check("sb_tx_drained", tx_exp.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
